if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage MIPS32 pipeline.
- Generates the fetch PC and chip-enable that drive the instruction memory (word address = pc>>2).
- Captures the returned instruction and its PC into the IF/ID pipeline register.
- Handles sequential fetch, branch redirect from ID, pipeline stalls, and exception flush redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first PC fetched after reset release.
- STALL_W, 3, width of stall vector ([0]=PC, [1]=IF, [2]=ID).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- stall  in  3  stall request vector from ctrl: [0] hold PC, [1] hold IF, [2] hold ID.
- flush  in  1  exception/eret flush from ctrl.
- flush_pc  in  32  redirect PC accompanying flush.
- branch_flag  in  1  taken branch/jump resolved in ID.
- branch_target  in  32  branch/jump destination.
- inst_i  in  32  instruction returned combinationally by instruction memory.
- pc  out  32  fetch address to instruction memory.
- ce  out  1  instruction memory chip enable.
- id_pc  out  32  IF/ID register: PC of instruction handed to ID.
- id_inst  out  32  IF/ID register: instruction handed to ID.
- fetch_cnt  out  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (rst=0 at clock edge): ce=0, pc=RESET_PC, id_pc=0, id_inst=0, fetch_cnt=0.
- ce: registered; becomes 1 on the first edge with rst=1 and stays 1 until the next reset.
- PC update priority, evaluated each edge with rst=1:
  1. ce==0 → pc=RESET_PC. The first fetch after release is therefore RESET_PC.
  2. flush → pc=flush_pc.
  3. stall[0] → pc holds.
  4. branch_flag → pc=branch_target.
  5. Otherwise pc=pc+4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- flush overrides stall and branch in the same cycle.
- Branch target arrives in ID while the delay-slot instruction is in IF. The delay slot is captured normally, with no squash here.
- IF/ID register priority, each edge with rst=1:
  1. ce==0 → id_pc=0, id_inst=0.
  2. flush → id_pc=0, id_inst=0 (NOP bubble).
  3. stall[1]=1 and stall[2]=0 → id_pc=0, id_inst=0 (bubble into ID).
  4. stall[1]=1 and stall[2]=1 → hold.
  5. stall[1]=0 → id_pc=pc, id_inst=inst_i.
- fetch_cnt increments by 1 (wrapping at 2^32) exactly on edges taking IF/ID case 5 with ce==1. It is unchanged otherwise and cleared only by reset.
- Reset mid-operation: all state returns to reset values on that edge regardless of stall/flush/branch. No partial updates.
- No combinational path from any input to any output.

Optional Feature:
- Macro: IF_ADDR_ALIGN_CHK_EN.
- With macro defined:
  - pc keeps the exact flush_pc/branch_target value, including bits [1:0].
  - Adds output port id_excp_adel (1 bit, reset 0), registered alongside id_inst.
  - When IF/ID case 5 captures a pc with pc[1:0]!=0: id_inst=0, id_excp_adel=1, fetch_cnt still increments.
  - In all bubble/reset/flush cases id_excp_adel=0. In hold it holds.
- Without macro: bits [1:0] of flush_pc and branch_target are forced to 0 when loaded into pc. Port id_excp_adel does not exist.

Test Plan:
- Reset release: hold rst=0 3 cycles, then rst=1 → cycle1 ce=1, pc=0x0; following cycles pc=0x4, 0x8. id_pc lags pc by one cycle, id_inst equals memory word; fetch_cnt=1, 2, 3….
- Branch: at pc=0x10 assert branch_flag=1, branch_target=0x100 for one cycle → next pc=0x100, then 0x104. The instruction at 0x10 (delay slot) reaches id_inst unsquashed.
- Stall: stall=3'b011 for 2 cycles at pc=0x20 → pc holds 0x20. id_pc/id_inst become 0 (bubble) and fetch_cnt is frozen. Then stall=3'b111 → IF/ID holds. Release → pc=0x24, counting resumes.
- Flush priority: same cycle flush=1, flush_pc=0x180, branch_flag=1, branch_target=0x300, stall=3'b111 → pc=0x180, id_pc=0, id_inst=0.
- Wrap and mid-op reset: force pc via flush_pc=0xFFFF_FFFC → next pc=0x0000_0000. Assert rst=0 during a branch → pc=RESET_PC, ce=0, fetch_cnt=0.
- IF_ADDR_ALIGN_CHK_EN: branch_target=0x102 → pc=0x102, next edge id_inst=0, id_excp_adel=1. Without macro the same stimulus gives pc=0x100 and normal fetch.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - fetch unit bundle: ctrl/ID redirect inputs, imem bus, IF/ID register outputs
interface if_fetch_unit_if #(
    parameter int STALL_W = 3
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        flush_pc;
    logic               branch_flag;
    logic [31:0]        branch_target;
    logic [31:0]        inst_i;
    logic [31:0]        pc;
    logic               ce;
    logic [31:0]        id_pc;
    logic [31:0]        id_inst;
    logic [31:0]        fetch_cnt;
`ifdef IF_ADDR_ALIGN_CHK_EN
    logic               id_excp_adel;
`endif

    modport master (
        input  stall, flush, flush_pc, branch_flag, branch_target, inst_i,
`ifdef IF_ADDR_ALIGN_CHK_EN
        output id_excp_adel,
`endif
        output pc, ce, id_pc, id_inst, fetch_cnt
    );

    modport slave (
        output stall, flush, flush_pc, branch_flag, branch_target, inst_i,
`ifdef IF_ADDR_ALIGN_CHK_EN
        input  id_excp_adel,
`endif
        input  pc, ce, id_pc, id_inst, fetch_cnt
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS32 instruction fetch stage with IF/ID register; optional IF_ADDR_ALIGN_CHK_EN
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STALL_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    if_fetch_unit_if.master bus
);

    logic [STALL_W-1:0] stall;
    logic [31:0]        flush_pc;
    logic [31:0]        branch_target;

    logic        ce_q;
    logic [31:0] pc_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_inst_q;
    logic [31:0] fetch_cnt_q;
    logic        adel_q;
    logic        misaligned;

    assign stall = bus.stall;

`ifdef IF_ADDR_ALIGN_CHK_EN
    // Redirect targets are kept verbatim so a bad target can be reported as AdEL in ID.
    assign flush_pc      = bus.flush_pc;
    assign branch_target = bus.branch_target;
    assign misaligned    = (pc_q[1:0] != 2'b00);
    assign bus.id_excp_adel = adel_q;
`else
    assign flush_pc      = {bus.flush_pc[31:2], 2'b00};
    assign branch_target = {bus.branch_target[31:2], 2'b00};
    assign misaligned    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            ce_q        <= 1'b0;
            pc_q        <= RESET_PC;
            id_pc_q     <= 32'd0;
            id_inst_q   <= 32'd0;
            fetch_cnt_q <= 32'd0;
            adel_q      <= 1'b0;
        end else begin
            ce_q <= 1'b1;

            if (!ce_q) begin
                pc_q <= RESET_PC;
            end else if (bus.flush) begin
                pc_q <= flush_pc;
            end else if (stall[0]) begin
                pc_q <= pc_q;
            end else if (bus.branch_flag) begin
                pc_q <= branch_target;
            end else begin
                pc_q <= pc_q + 32'd4;
            end

            // stall[1] without stall[2] means ID advances, so it must see a bubble.
            if (!ce_q || bus.flush || (stall[1] && !stall[2])) begin
                id_pc_q   <= 32'd0;
                id_inst_q <= 32'd0;
                adel_q    <= 1'b0;
            end else if (stall[1]) begin
                id_pc_q   <= id_pc_q;
                id_inst_q <= id_inst_q;
                adel_q    <= adel_q;
            end else begin
                id_pc_q     <= pc_q;
                id_inst_q   <= misaligned ? 32'd0 : bus.inst_i;
                adel_q      <= misaligned;
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign bus.ce        = ce_q;
    assign bus.pc        = pc_q;
    assign bus.id_pc     = id_pc_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.fetch_cnt = fetch_cnt_q;

`ifndef IF_ADDR_ALIGN_CHK_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, adel_q, misaligned, bus.flush_pc[1:0], bus.branch_target[1:0]};
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with directed vectors
module tb_if_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.STALL_W(3)) bus ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .STALL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h2408_0000 | {16'd0, a[17:2]};
    endfunction

    assign bus.inst_i = imem(bus.pc);

    typedef struct {
        int          idx;
        logic        ce;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic [31:0] cnt;
        logic        adel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    bit   done   = 1'b0;

`ifdef IF_ADDR_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] st, input logic f, input logic [31:0] fpc,
                        input logic b, input logic [31:0] bt,
                        input logic e_ce, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                        input logic [31:0] e_idinst, input logic [31:0] e_cnt, input logic e_adel);
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.stall         = st;
        bus.flush         = f;
        bus.flush_pc      = fpc;
        bus.branch_flag   = b;
        bus.branch_target = bt;
        e.idx = vec_no; e.ce = e_ce; e.pc = e_pc; e.id_pc = e_idpc;
        e.id_inst = e_idinst; e.cnt = e_cnt; e.adel = e_adel;
        exp_q.push_back(e);
        vec_no++;
    endtask

    // Monitor: every edge the DUT presents a new register state; compare against the queued vector.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ce",        e.idx, {31'd0, bus.ce}, {31'd0, e.ce});
                chk("pc",        e.idx, bus.pc,          e.pc);
                chk("id_pc",     e.idx, bus.id_pc,       e.id_pc);
                chk("id_inst",   e.idx, bus.id_inst,     e.id_inst);
                chk("fetch_cnt", e.idx, bus.fetch_cnt,   e.cnt);
`ifdef IF_ADDR_ALIGN_CHK_EN
                chk("id_excp_adel", e.idx, {31'd0, bus.id_excp_adel}, {31'd0, e.adel});
`endif
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus.stall = 3'b000; bus.flush = 1'b0; bus.flush_pc = 32'd0;
        bus.branch_flag = 1'b0; bus.branch_target = 32'd0;

        // reset held three cycles
        for (int i = 0; i < 3; i++)
            step(0, 3'b000, 0, 0, 0, 0,          0, 32'h0,   32'h0,  32'h0,       0, 0);
        // release: first fetch at RESET_PC, IF/ID stays empty on that edge
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h0,   32'h0,  32'h0,       0, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h4,   32'h0,  imem(32'h0), 1, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h8,   32'h4,  imem(32'h4), 2, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'hC,   32'h8,  imem(32'h8), 3, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h10,  32'hC,  imem(32'hC), 4, 0);
        // branch at pc=0x10, delay slot captured
        step(1, 3'b000, 0, 0, 1, 32'h100,        1, 32'h100, 32'h10, imem(32'h10), 5, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h104, 32'h100, imem(32'h100), 6, 0);
        step(1, 3'b000, 0, 0, 1, 32'h20,         1, 32'h20,  32'h104, imem(32'h104), 7, 0);
        // stall 011 twice: pc holds, bubble into ID
        step(1, 3'b011, 0, 0, 0, 0,              1, 32'h20,  32'h0,  32'h0,       7, 0);
        step(1, 3'b011, 0, 0, 0, 0,              1, 32'h20,  32'h0,  32'h0,       7, 0);
        step(1, 3'b111, 0, 0, 0, 0,              1, 32'h20,  32'h0,  32'h0,       7, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h24,  32'h20, imem(32'h20), 8, 0);
        // full stall with live IF/ID content holds it
        step(1, 3'b111, 0, 0, 0, 0,              1, 32'h24,  32'h20, imem(32'h20), 8, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h28,  32'h24, imem(32'h24), 9, 0);
        // flush beats stall and branch
        step(1, 3'b111, 1, 32'h180, 1, 32'h300,  1, 32'h180, 32'h0,  32'h0,       9, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h184, 32'h180, imem(32'h180), 10, 0);
        // stall[0] beats branch, IF/ID still captures
        step(1, 3'b001, 0, 0, 1, 32'h300,        1, 32'h184, 32'h184, imem(32'h184), 11, 0);
        // wrap
        step(1, 3'b000, 1, 32'hFFFF_FFFC, 0, 0,  1, 32'hFFFF_FFFC, 32'h0, 32'h0, 11, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h0, 32'hFFFF_FFFC, imem(32'hFFFF_FFFC), 12, 0);
        // misaligned branch and flush targets
        if (ALIGN_EN) begin
            step(1, 3'b000, 0, 0, 1, 32'h102,    1, 32'h102, 32'h0,   imem(32'h0), 13, 0);
            step(1, 3'b000, 0, 0, 0, 0,          1, 32'h106, 32'h102, 32'h0,       14, 1);
            step(1, 3'b000, 1, 32'h203, 0, 0,    1, 32'h203, 32'h0,   32'h0,       14, 0);
            step(1, 3'b000, 0, 0, 0, 0,          1, 32'h207, 32'h203, 32'h0,       15, 1);
        end else begin
            step(1, 3'b000, 0, 0, 1, 32'h102,    1, 32'h100, 32'h0,   imem(32'h0), 13, 0);
            step(1, 3'b000, 0, 0, 0, 0,          1, 32'h104, 32'h100, imem(32'h100), 14, 0);
            step(1, 3'b000, 1, 32'h203, 0, 0,    1, 32'h200, 32'h0,   32'h0,       14, 0);
            step(1, 3'b000, 0, 0, 0, 0,          1, 32'h204, 32'h200, imem(32'h200), 15, 0);
        end
        // reset during a branch
        step(0, 3'b000, 0, 0, 1, 32'h300,        0, 32'h0,   32'h0,  32'h0,       0, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h0,   32'h0,  32'h0,       0, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h4,   32'h0,  imem(32'h0), 1, 0);
        step(1, 3'b000, 0, 0, 0, 0,              1, 32'h8,   32'h4,  imem(32'h4), 2, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 0, exp_q.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule
